// File: rtl/sag_pack.sv
// sag_pack: streaming bit packer placed behind a pext (parallel bit extract) stage.
// Extracted bits are appended LSB-first into a 16-bit accumulator and leave as
// 8-bit bytes over valid/ready. A packet tail is flushed as a tagged partial byte.

module pext (
   input  logic [7:0] data,
   input  logic [7:0] mask,
   output logic [7:0] result,
   output logic [3:0] count
);
   logic [7:0] res_s;
   logic [3:0] cnt_s;

   // Gather mask-selected data bits into the low end, keeping their order
   always_comb begin
      res_s = 8'h00;
      cnt_s = 4'd0;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) begin
            res_s[cnt_s[2:0]] = data[i];
            cnt_s             = cnt_s + 4'd1;
         end else begin
            cnt_s = cnt_s;
         end
      end
   end

   assign result = res_s;
   assign count  = cnt_s;
endmodule

module sag_pack (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [7:0] in_mask,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [3:0] out_nbits,
   output logic       out_last
);
   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;

   logic [15:0] acc_r;
   logic [3:0]  cnt_r;
   logic [1:0]  state_r;

   logic [7:0]  x_s;
   logic [3:0]  n_s;
   logic        in_fire_s;
   logic        out_fire_s;
   logic [15:0] acc_sh_s;
   logic [3:0]  cnt_sh_s;
   logic [15:0] acc_nx_s;
   logic [3:0]  cnt_nx_s;
   logic [1:0]  state_nx_s;

   pext u_pext (
      .data   (in_data),
      .mask   (in_mask),
      .result (x_s),
      .count  (n_s)
   );

   // Output side is a pure decode of the accumulator registers; the only
   // combinational pass-through is out_ready -> in_ready, which lets a full
   // accumulator drain and refill in the same cycle.
   assign out_valid  = (cnt_r >= 4'd8) || (state_r == ST_FLUSH);
   assign out_data   = acc_r[7:0];
   assign out_nbits  = (cnt_r >= 4'd8) ? 4'd8 : cnt_r;
   assign out_last   = (state_r == ST_FLUSH) && (cnt_r <= 4'd8);
   assign in_ready   = (state_r == ST_RUN) && ((cnt_r < 4'd8) || out_ready);

   assign out_fire_s = out_valid && out_ready;
   assign in_fire_s  = in_valid && in_ready;

   // Next accumulator: retire the outgoing byte first, then append new bits
   // above whatever remains (an accepted word always sees fewer than 8 bits left)
   always_comb begin
      acc_sh_s = acc_r;
      cnt_sh_s = cnt_r;
      if (out_fire_s) begin
         acc_sh_s = {8'h00, acc_r[15:8]};
         cnt_sh_s = (cnt_r >= 4'd8) ? (cnt_r - 4'd8) : 4'd0;
      end else begin
         acc_sh_s = acc_r;
         cnt_sh_s = cnt_r;
      end

      acc_nx_s = acc_sh_s;
      cnt_nx_s = cnt_sh_s;
      if (in_fire_s) begin
         acc_nx_s = acc_sh_s | ({8'h00, x_s} << cnt_sh_s);
         cnt_nx_s = cnt_sh_s + n_s;
      end else begin
         acc_nx_s = acc_sh_s;
         cnt_nx_s = cnt_sh_s;
      end
   end

   // Packet framing: enter FLUSH on the last word, leave when the last byte fires
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (in_fire_s && in_last) begin
               state_nx_s = ST_FLUSH;
            end else begin
               state_nx_s = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (out_fire_s && out_last) begin
               state_nx_s = ST_RUN;
            end else begin
               state_nx_s = ST_FLUSH;
            end
         end
         default: begin
            state_nx_s = ST_RUN;
         end
      endcase
   end

   // Accumulator, bit count and framing state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_r   <= 16'h0000;
         cnt_r   <= 4'd0;
         state_r <= ST_RUN;
      end else begin
         acc_r   <= acc_nx_s;
         cnt_r   <= cnt_nx_s;
         state_r <= state_nx_s;
      end
   end
endmodule

// File: tb/tb_sag_pack.sv
// Self-checking bench for sag_pack: directed scenarios plus randomized packets
// checked against a bit-queue reference model of the packing rules.

module tb_sag_pack;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [7:0] in_mask;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] out_nbits;
   logic       out_last;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: pending bits of the current packet, expected and observed bytes
   // Byte records are {last, nbits[3:0], data[7:0]}
   bit          pend_q[$];
   logic [12:0] exp_q[$];
   logic [12:0] obs_q[$];
   bit          rnd_done;

   always #5 clk = ~clk;

   sag_pack dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_nbits (out_nbits),
      .out_last  (out_last)
   );

   // Model of one accepted word. A full byte already waiting must leave before
   // more bits can be accepted, so it is emitted (non-last) first. On the last
   // word the remainder goes out as full bytes, then one final tagged byte.
   function automatic void model_accept(logic [7:0] d, logic [7:0] m, logic l);
      logic [7:0] b;
      int         k;
      if (pend_q.size() >= 8) begin
         b = 8'h00;
         for (int i = 0; i < 8; i++) b[i] = pend_q.pop_front();
         exp_q.push_back({1'b0, 4'd8, b});
      end
      for (int i = 0; i < 8; i++) if (m[i]) pend_q.push_back(d[i]);
      if (l) begin
         while (pend_q.size() > 8) begin
            b = 8'h00;
            for (int i = 0; i < 8; i++) b[i] = pend_q.pop_front();
            exp_q.push_back({1'b0, 4'd8, b});
         end
         b = 8'h00;
         k = pend_q.size();
         for (int i = 0; i < k; i++) b[i] = pend_q.pop_front();
         exp_q.push_back({1'b1, 4'(k), b});
      end
   endfunction

   // Observe handshakes mid-cycle; values are stable until the next rising edge
   always @(negedge clk) begin
      if (!rst) begin
         if (in_valid && in_ready) model_accept(in_data, in_mask, in_last);
         if (out_valid && out_ready) obs_q.push_back({out_last, out_nbits, out_data});
      end
   end

   task automatic clear_model();
      pend_q.delete();
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_mask  = 8'($urandom);
      in_last  = 1'($urandom);
   endtask

   // Present one word and hold it until accepted (bounded wait)
   task automatic send_word(input logic [7:0] d, input logic [7:0] m, input logic l);
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_mask  = m;
      in_last  = l;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) begin
            acc = 1'b1;
            break;
         end
      end
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_timeout: in_ready=%0b after 200 cycles, required 1", in_ready);
      end
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      out_ready = 1'b0;
      idle_inputs();
      clear_model();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({out_valid, in_ready, out_data, out_nbits, out_last} !== {1'b0, 1'b1, 8'h00, 4'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_vals: got v=%0b rdy=%0b d=%h nb=%0d l=%0b, required 0 1 00 0 0",
                  out_valid, in_ready, out_data, out_nbits, out_last);
      end
      @(posedge clk);
      #1;
      send_word(8'h5A, 8'hFF, 1'b0);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_prefill: out_valid=%0b, required 1", out_valid);
      end
      #2;
      rst = 1'b1;
      clear_model();
      #1;
      n_cmp++;
      if ({out_valid, in_ready, out_data, out_nbits, out_last} !== {1'b0, 1'b1, 8'h00, 4'd0, 1'b0}) begin
         n_bad++;
         $display("FAIL reset_async: got v=%0b rdy=%0b d=%h nb=%0d l=%0b, required 0 1 00 0 0",
                  out_valid, in_ready, out_data, out_nbits, out_last);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_full_byte();
      clear_model();
      out_ready = 1'b0;
      send_word(8'hA5, 8'hFF, 1'b1);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, out_valid, out_data, out_nbits, out_last} !== {1'b0, 1'b1, 8'hA5, 4'd8, 1'b1}) begin
         n_bad++;
         $display("FAIL full_byte_hold: got rdy=%0b v=%0b d=%h nb=%0d l=%0b, required 0 1 a5 8 1",
                  in_ready, out_valid, out_data, out_nbits, out_last);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_cycles(3);
      n_cmp++;
      if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 4'd8, 8'hA5}) begin
         n_bad++;
         $display("FAIL full_byte_out: got %0d bytes first=%h, required 1 byte 18a5",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 13'h0);
      end
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
         n_bad++;
         $display("FAIL full_byte_idle: got rdy=%0b v=%0b, required 1 0", in_ready, out_valid);
      end
   endtask

   task automatic test_nibble();
      clear_model();
      out_ready = 1'b1;
      send_word(8'hB2, 8'hF0, 1'b0);
      send_word(8'hB2, 8'hF0, 1'b1);
      wait_cycles(4);
      n_cmp++;
      if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 4'd8, 8'hBB}) begin
         n_bad++;
         $display("FAIL nibble_out: got %0d bytes first=%h, required 1 byte 18bb",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 13'h0);
      end
   endtask

   task automatic test_partial_flush();
      clear_model();
      out_ready = 1'b1;
      send_word(8'hFF, 8'h0F, 1'b0);
      send_word(8'hFF, 8'h0F, 1'b0);
      send_word(8'hFF, 8'h0F, 1'b1);
      wait_cycles(4);
      n_cmp++;
      if (obs_q.size() != 2 || obs_q[0] !== {1'b0, 4'd8, 8'hFF} || obs_q[1] !== {1'b1, 4'd4, 8'h0F}) begin
         n_bad++;
         $display("FAIL partial_flush: got %0d bytes %h %h, required 2 bytes 08ff 140f",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 13'h0,
                  (obs_q.size() > 1) ? obs_q[1] : 13'h0);
      end
   endtask

   task automatic test_empty_tail();
      clear_model();
      out_ready = 1'b1;
      send_word(8'h6C, 8'h00, 1'b1);
      wait_cycles(3);
      n_cmp++;
      if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 4'd0, 8'h00}) begin
         n_bad++;
         $display("FAIL empty_tail: got %0d bytes first=%h, required 1 byte 1000",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 13'h0);
      end
   endtask

   task automatic test_backpressure_reset();
      logic [7:0] d[5];
      logic [7:0] held;
      clear_model();
      for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
      out_ready = 1'b0;
      send_word(d[0], 8'hFF, 1'b0);
      in_valid = 1'b1;
      in_data  = d[1];
      in_mask  = 8'hFF;
      in_last  = 1'b0;
      @(negedge clk);
      held = out_data;
      n_cmp++;
      if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, d[0]}) begin
         n_bad++;
         $display("FAIL bp_stall: got rdy=%0b v=%0b d=%h, required 0 1 %h", in_ready, out_valid, out_data, d[0]);
      end
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({in_ready, out_data, out_nbits, out_last} !== {1'b0, held, 4'd8, 1'b0} || obs_q.size() != 0) begin
         n_bad++;
         $display("FAIL bp_stable: got rdy=%0b d=%h nb=%0d l=%0b n=%0d, required 0 %h 8 0 0",
                  in_ready, out_data, out_nbits, out_last, obs_q.size(), held);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send_word(d[1], 8'hFF, 1'b0);
      send_word(d[2], 8'hFF, 1'b0);
      send_word(d[3], 8'hFF, 1'b0);
      send_word(d[4], 8'hFF, 1'b1);
      wait_cycles(4);
      n_cmp++;
      if (obs_q.size() != 5) begin
         n_bad++;
         $display("FAIL bp_count: got %0d bytes, required 5", obs_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (obs_q[i] !== {(i == 4), 4'd8, d[i]}) begin
               n_bad++;
               $display("FAIL bp_byte%0d: got %h, required %h", i, obs_q[i], {(i == 4), 4'd8, d[i]});
            end
         end
      end
      // Reset while a flush byte is pending must drop it
      clear_model();
      out_ready = 1'b0;
      send_word(8'hC3, 8'h0F, 1'b1);
      @(negedge clk);
      #2;
      rst = 1'b1;
      clear_model();
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      wait_cycles(3);
      n_cmp++;
      if (obs_q.size() != 0 || {out_valid, in_ready} !== 2'b01) begin
         n_bad++;
         $display("FAIL flush_reset: got %0d bytes v=%0b rdy=%0b, required 0 bytes 0 1",
                  obs_q.size(), out_valid, in_ready);
      end
      send_word(8'h3C, 8'hFF, 1'b1);
      wait_cycles(3);
      n_cmp++;
      if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 4'd8, 8'h3C}) begin
         n_bad++;
         $display("FAIL flush_reset_clean: got %0d bytes first=%h, required 1 byte 183c",
                  obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 13'h0);
      end
   endtask

   task automatic test_random();
      clear_model();
      rnd_done = 1'b0;
      fork
         begin
            for (int p = 0; p < 40; p++) begin
               int nw = $urandom_range(1, 6);
               for (int w = 0; w < nw; w++) begin
                  int         sel = $urandom_range(0, 3);
                  logic [7:0] m   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
                  repeat ($urandom_range(0, 2)) @(posedge clk);
                  #1;
                  send_word(8'($urandom), m, (w == nw - 1));
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      out_ready = 1'b1;
      wait_cycles(40);
      n_cmp++;
      if (obs_q.size() != exp_q.size() || out_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rand_count: got %0d bytes v=%0b, required %0d bytes v=0",
                  obs_q.size(), out_valid, exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_bad++;
            $display("FAIL rand_byte%0d: got %h, required %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_full_byte();
      test_nibble();
      test_partial_flush();
      test_empty_tail();
      test_backpressure_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/sag_pack.md
# sag_pack

Streaming bit packer that sits directly downstream of the combinational `pext` stage. Each accepted input word (data, mask) is compressed by an internal `pext` instance to popcount(mask) bits. These bits are appended LSB-first to a bit accumulator, and the block emits packed 8-bit output bytes over a valid/ready interface. On end of packet, any residual bits are flushed as a final partial byte tagged with its bit count.

## Interface
- No parameters; data path fixed at 8 bits.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid && in_ready`.
- `in_data`  in  8  data word fed to `pext` data input.
- `in_mask`  in  8  mask fed to `pext` control input; popcount(mask) bits are extracted.
- `in_last`  in  1  marks final word of a packet.
- `out_valid`  out  1  output byte valid.
- `out_ready`  in  1  output byte consumed when `out_valid && out_ready`.
- `out_data`  out  8  packed byte; the earliest extracted bit is in bit 0.
- `out_nbits`  out  4  number of meaningful bits in `out_data`, 0..8.
- `out_last`  out  1  final byte of packet.

## Operation
- Registers:
  - `acc[15:0]` holds the bit accumulator.
  - `cnt[3:0]` holds the valid-bit count, 0..15.
  - `state` is one of RUN or FLUSH.
- Invariant: `acc` bits at positions ≥ `cnt` are always 0.
- Input extraction: `x = pext(in_data, in_mask)` and `n = popcount(in_mask)`, range 0..8. Bits of `x` at positions ≥ `n` are 0.
- `out_valid` = `(cnt >= 8) || (state == FLUSH)`.
- `out_data` = `acc[7:0]`.
- `out_nbits` = 8 if `cnt >= 8`, otherwise `cnt`.
- `out_last` = `(state == FLUSH) && (cnt <= 8)`.
- `in_ready` = `(state == RUN) && ((cnt < 8) || out_ready)`.
  - This is a combinational path from `out_ready` to `in_ready`, and it is permitted.
- Output fire:
  - Shift `acc` right by 8 (zero fill).
  - `cnt` decreases by min(`cnt`, 8).
- Input fire:
  - `acc[c' +: 8]` is ORed with `x`, where `c'` is the count after any same-cycle output shift.
  - `cnt` = `c' + n`, which never exceeds 15.
- Simultaneous input and output fire in RUN is legal. The shift is applied first, then the append.
- RUN → FLUSH on an accepted word with `in_last = 1`.
- FLUSH behaviour:
  - `in_ready = 0`.
  - Bytes with `cnt > 8` are emitted with `out_last = 0`.
  - The byte with `cnt <= 8` is emitted with `out_last = 1`, `out_nbits = cnt`, and upper bits 0.
- Empty tail: if `cnt == 0` in FLUSH, one byte is still emitted with `out_data = 0`, `out_nbits = 0`, `out_last = 1`.
- FLUSH → RUN when the `out_last` byte fires. At that point `cnt = 0` and `acc = 0`.
- No-packet-loss rule: every accepted word contributes exactly `n` bits. Within a packet, bits are never reordered or duplicated.

## Timing
- Reset (async assert, sync release into `clk` domain) sets:
  - `acc = 0`, `cnt = 0`, `state = RUN`.
  - Outputs: `out_valid = 0`, `out_data = 0`, `out_nbits = 0`, `out_last = 0`, `in_ready = 1`.
- Latency: a byte completed by an input fire at edge k is presented with `out_valid = 1` in the cycle after edge k.
- Throughput: one input word per cycle sustained while `out_ready = 1`.
- Backpressure: while `out_valid && !out_ready`, `out_data`, `out_nbits` and `out_last` stay stable.
- `in_ready` drops as soon as `cnt >= 8` and `out_ready = 0`.
- Reset asserted mid-packet or mid-FLUSH discards all accumulated bits immediately; no partial byte is emitted.
- `in_*` values while `in_valid = 0` are ignored. `in_last` is ignored unless the word fires.

## Test plan
- Reset check: assert `rst` for 3 cycles, then release → `out_valid = 0`, `in_ready = 1`, `cnt = 0`. Reassert `rst` asynchronously between edges → outputs return to reset values without a clock edge.
- Full-byte packet: data 0xA5, mask 0xFF, last=1 → one byte 0xA5 with nbits=8, last=1, and `in_ready = 0` until it fires.
- Nibble packing: data 0xB2, mask 0xF0 twice, last on the second word → byte 0xBB with nbits=8, last=1.
- Partial flush: three words of data 0xFF, mask 0x0F, last on the third → byte 0xFF (nbits=8, last=0), then 0x0F (nbits=4, last=1).
- Empty tail: single word with mask 0x00, last=1 → byte 0x00 with nbits=0, last=1.
- Backpressure and reset mid-packet:
  - Hold `out_ready = 0` while streaming mask 0xFF words → `in_ready` falls after the first accept and `out_data` holds stable.
  - Release `out_ready` → one byte per cycle with no loss.
  - Assert `rst` during FLUSH → no last byte is emitted, and a new packet starts clean.
